mlp_feat_serializer: RTL
========================

// Module: mlp_feat_serializer
// PURPOSE
// - Upstream feeder of the MLP trigger core (mlp_stcf).
// - Accepts one parallel feature vector per handshake and buffers it in a small FIFO.
// - Emits the vector as a serial 16-bit AXI-Stream, feature 0 first, with s_tlast on the final feature.
// - Output connects directly to mlp_stcf s_tvalid/s_tready/s_tdata/s_tlast (first layer input_dim = 4).
// PARAMETERS
// - NUM_FEAT  4   features per vector; range 2..15.
// - DEPTH     4   FIFO depth in vectors; power of 2, 2..16.
// - AW        2   log2(DEPTH); must equal clog2(DEPTH).
// PORTS
// - aclk       in   1            single clock; all logic on its rising edge.
// - areset     in   1            reset, synchronous, active-high.
// - v_tvalid   in   1            parallel vector valid.
// - v_tready   out  1            vector accepted when v_tvalid & v_tready.
// - v_tdata    in   16*NUM_FEAT  features, signed Q8.8; feature k = bits [16k+15:16k].
// - m_tvalid   out  1            serial word valid.
// - m_tready   in   1            downstream ready.
// - m_tdata    out  16           current feature word.
// - m_tlast    out  1            high on feature NUM_FEAT-1 of each vector.
// - fill       out  AW+1         FIFO occupancy in vectors, 0..DEPTH.
// - vec_cnt    out  16           vectors fully emitted; wraps at 0xFFFF -> 0.
// BEHAVIOUR
// - Reset: clears wr_ptr, rd_ptr, fill, feat_idx and vec_cnt to 0.
//   - While areset is high: m_tvalid=0, m_tlast=0, v_tready=0.
//   - m_tdata is don't-care during reset.
// - Storage: DEPTH x (16*NUM_FEAT) register array; wr_ptr and rd_ptr wrap modulo DEPTH.
// - v_tready = !areset & (fill != DEPTH).
//   - Combinational from state only; it never depends on m_tready.
//   - A full FIFO accepts nothing, even in a cycle where a pop occurs.
// - Push on v_tvalid & v_tready: store v_tdata at wr_ptr; wr_ptr++.
// - m_tvalid = (fill != 0). m_tdata = head[feat_idx]. m_tlast = (feat_idx == NUM_FEAT-1).
// - Word handshake (m_tvalid & m_tready):
//   - If !m_tlast: feat_idx++.
//   - If m_tlast (pop): feat_idx <= 0, rd_ptr++, vec_cnt++.
// - Simultaneous push and pop: fill unchanged. Otherwise fill += push - pop.
// - Latency: a vector pushed into an empty FIFO at edge t gives m_tvalid=1 and word 0 in the cycle after edge t.
//   - No combinational path from v_* to m_*.
// - Throughput: one word per cycle while m_tready=1; one vector every NUM_FEAT cycles.
// - Stall: m_tdata and m_tlast hold stable while m_tvalid & !m_tready. m_tvalid never drops without a handshake.
// - Empty: m_tvalid=0, feat_idx stays 0.
// - Vectors are never dropped or reordered; backpressure is the only flow control.
// - Reset mid-vector: the partial vector and all buffered vectors are discarded.
//   - The first output after reset starts at feature 0 of the next accepted vector.
// TESTING
// - Single vector {4,3,2,1}, m_tready=1.
//   - Expect words 0x0001, 0x0002, 0x0003, 0x0004 on consecutive cycles, first one cycle after the push.
//   - m_tlast only on 0x0004; vec_cnt=1; fill back to 0.
// - Fill with m_tready=0: push 5 vectors back-to-back.
//   - Expect the first 4 accepted, then v_tready=0 and fill=4.
//   - Release m_tready: expect 16 words in push order, then the 5th vector after a slot frees.
// - Random m_tready (50%): 100 random vectors.
//   - Scoreboard matches every word and every m_tlast position.
//   - m_tdata stable during every stall; vec_cnt=100.
// - Simultaneous push/pop at fill=2 on a last-word handshake: fill stays 2, pointers both advance.
// - Reset asserted after word 1 of a vector, with fill=3.
//   - Next cycle: m_tvalid=0, fill=0.
//   - Next vector {8,7,6,5}: emits 0x0005 first.
// - Wrap: preset vec_cnt to 0xFFFF via 65535 vectors, or force in sim; one more vector gives vec_cnt=0.

Source files
------------

// File: rtl/mlp_feat_serializer_if.sv
// rtl/mlp_feat_serializer_if.sv - parallel-vector input and serial-word output handshake bundle
interface mlp_feat_serializer_if #(
   parameter int NUM_FEAT = 4
);
   logic                   v_tvalid;
   logic                   v_tready;
   logic [16*NUM_FEAT-1:0] v_tdata;
   logic                   m_tvalid;
   logic                   m_tready;
   logic [15:0]            m_tdata;
   logic                   m_tlast;

   // Serializer side: consumes vectors, produces serial words
   modport master (
      input  v_tvalid, v_tdata, m_tready,
      output v_tready, m_tvalid, m_tdata, m_tlast
   );

   // Environment side: produces vectors, consumes serial words
   modport slave (
      output v_tvalid, v_tdata, m_tready,
      input  v_tready, m_tvalid, m_tdata, m_tlast
   );
endinterface

// File: rtl/mlp_feat_serializer.sv
// rtl/mlp_feat_serializer.sv - buffers parallel feature vectors and emits them as a serial word stream
module mlp_feat_serializer #(
   parameter int NUM_FEAT = 4,
   parameter int DEPTH    = 4,
   parameter int AW       = 2
) (
   input  logic                 aclk,
   input  logic                 areset,
   mlp_feat_serializer_if.master bus,
   output logic [AW:0]          fill,
   output logic [15:0]          vec_cnt
);
   localparam logic [AW:0] FILL_FULL = (AW+1)'(DEPTH);
   localparam logic [3:0]  LAST_IDX  = 4'(NUM_FEAT-1);

   logic [16*NUM_FEAT-1:0] mem_q [DEPTH];
   logic [16*NUM_FEAT-1:0] mem_d [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            fill_q, fill_d;
   logic [3:0]             feat_idx_q, feat_idx_d;
   logic [15:0]            vec_cnt_q, vec_cnt_d;

   logic [16*NUM_FEAT-1:0] head;
   logic                   push;
   logic                   word_hs;
   logic                   pop;

   // Handshake outputs come from registered state only, so nothing on v_* reaches m_*
   always_comb begin
      head         = mem_q[rd_ptr_q];
      bus.v_tready = !areset && (fill_q != FILL_FULL);
      bus.m_tvalid = !areset && (fill_q != '0);
      bus.m_tlast  = !areset && (feat_idx_q == LAST_IDX);
      bus.m_tdata  = head[15:0];
      for (int k = 0; k < NUM_FEAT; k++) begin
         if (feat_idx_q == 4'(k)) begin
            bus.m_tdata = head[16*k +: 16];
         end
      end
   end

   // Next-state: store on push, step through features, retire the head on its last word
   always_comb begin
      push       = bus.v_tvalid && bus.v_tready;
      word_hs    = bus.m_tvalid && bus.m_tready;
      pop        = word_hs && bus.m_tlast;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      feat_idx_d = feat_idx_q;
      vec_cnt_d  = vec_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.v_tdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end

      if (word_hs) begin
         if (bus.m_tlast) begin
            feat_idx_d = '0;
            rd_ptr_d   = rd_ptr_q + AW'(1);
            vec_cnt_d  = vec_cnt_q + 16'd1;
         end else begin
            feat_idx_d = feat_idx_q + 4'd1;
         end
      end

      if (push && !pop) begin
         fill_d = fill_q + (AW+1)'(1);
      end else if (pop && !push) begin
         fill_d = fill_q - (AW+1)'(1);
      end
   end

   // Control state; reset discards any buffered or partially emitted vectors
   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         feat_idx_q <= '0;
         vec_cnt_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         feat_idx_q <= feat_idx_d;
         vec_cnt_q  <= vec_cnt_d;
      end
   end

   // Vector storage needs no reset: contents are only visible while fill is nonzero
   always_ff @(posedge aclk) begin
      mem_q <= mem_d;
   end

   assign fill    = fill_q;
   assign vec_cnt = vec_cnt_q;
endmodule
